// File: rtl/bsg_chip_pkg.sv
// Shared chip-level types and constants for the SDR link reset sequencer.
package bsg_chip_pkg;

  typedef enum logic [2:0] {
    HOLD,
    TOK_ON,
    TOK_OFF,
    UP_REL,
    DN_REL,
    CORE_REL,
    DONE
  } bsg_link_sdr_reset_state_e;

  localparam int link_reset_step_cycles_gp  = 4;
  localparam int link_reset_token_cycles_gp = 4;

  // The dwell counter must hold the largest terminal count (dwell-1), at least one bit.
  function automatic int dwell_count_width(input int step_cycles, input int token_cycles);
    int longest;
    longest = (step_cycles > token_cycles) ? step_cycles : token_cycles;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/bsg_link_sdr_reset_dwell_timer.sv
// Counts cycles since the last clear; expired_o is high while the count sits at the terminal value.
module bsg_link_sdr_reset_dwell_timer #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] dwell_last_i,
  output logic               expired_o
);

  logic [width_p-1:0] count_r;

  // Holding at the terminal value keeps the count from wrapping inside a state.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_r <= '0;
    end else if (!expired_o) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign expired_o = (count_r == dwell_last_i);

endmodule

// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Orders the resets of one bidirectional SDR link with fixed dwell times; reruns on start_i in DONE.
// Optional completed-sequence counter: define BSG_LINK_SDR_RESET_SEQ_COUNT_EN.
module bsg_link_sdr_reset_sequencer
  import bsg_chip_pkg::*;
#(
  parameter int step_cycles_p  = link_reset_step_cycles_gp,
  parameter int token_cycles_p = link_reset_token_cycles_gp
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
  , parameter int count_width_p = 8
`endif
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic uplink_reset_o,
  output logic async_token_reset_o,
  output logic downlink_reset_o,
  output logic downstream_reset_o,
  output logic busy_o,
  output logic done_o
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
  , output logic [count_width_p-1:0] seq_count_o
`endif
);

  localparam int cnt_w = dwell_count_width(step_cycles_p, token_cycles_p);
  localparam logic [cnt_w-1:0] step_last  = cnt_w'(step_cycles_p - 1);
  localparam logic [cnt_w-1:0] token_last = cnt_w'(token_cycles_p - 1);

  bsg_link_sdr_reset_state_e state_r;
  logic [cnt_w-1:0] dwell_last;
  logic             expired;
  logic             advance;

  assign dwell_last = (state_r == TOK_ON) ? token_last : step_last;
  // DONE has no dwell; it leaves only on a start request.
  assign advance    = (state_r == DONE) ? start_i : expired;

  bsg_link_sdr_reset_dwell_timer #(
    .width_p(cnt_w)
  ) dwell_timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (advance),
    .dwell_last_i(dwell_last),
    .expired_o   (expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r             <= HOLD;
      uplink_reset_o      <= 1'b1;
      async_token_reset_o <= 1'b0;
      downlink_reset_o    <= 1'b1;
      downstream_reset_o  <= 1'b1;
      busy_o              <= 1'b1;
      done_o              <= 1'b0;
    end else if (advance) begin
      case (state_r)
        HOLD: begin
          state_r             <= TOK_ON;
          async_token_reset_o <= 1'b1;
        end
        TOK_ON: begin
          state_r             <= TOK_OFF;
          async_token_reset_o <= 1'b0;
        end
        TOK_OFF: begin
          state_r        <= UP_REL;
          uplink_reset_o <= 1'b0;
        end
        UP_REL: begin
          state_r          <= DN_REL;
          downlink_reset_o <= 1'b0;
        end
        DN_REL: begin
          state_r            <= CORE_REL;
          downstream_reset_o <= 1'b0;
        end
        CORE_REL: begin
          state_r <= DONE;
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r             <= HOLD;
          uplink_reset_o      <= 1'b1;
          async_token_reset_o <= 1'b0;
          downlink_reset_o    <= 1'b1;
          downstream_reset_o  <= 1'b1;
          busy_o              <= 1'b1;
          done_o              <= 1'b0;
        end
      endcase
    end
  end

`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seq_count_o <= '0;
    end else if (state_r == CORE_REL && expired && seq_count_o != '1) begin
      seq_count_o <= seq_count_o + 1'b1;
    end
  end
`endif

  // The token pulse lives entirely inside the upstream io reset, and releases stay ordered.
  tok_inside_uplink_reset: assert property (@(posedge clk_i) async_token_reset_o |-> uplink_reset_o);
  downlink_after_uplink:   assert property (@(posedge clk_i) !downlink_reset_o |-> !uplink_reset_o);
  core_after_downlink:     assert property (@(posedge clk_i) !downstream_reset_o |-> !downlink_reset_o);
  done_after_core:         assert property (@(posedge clk_i) done_o |-> !downstream_reset_o);

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Directed bench for bsg_link_sdr_reset_sequencer: two instances (step=4/token=4 and step=1/token=3).
module tb_bsg_link_sdr_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1, start1, reset2, start2;
  logic up1, tok1, dn1, ds1, busy1, done1;
  logic up2, tok2, dn2, ds2, busy2, done2;
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
  logic [1:0] cnt1;
  logic [7:0] cnt2;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] RST_VEC = 6'b101110;

  bsg_link_sdr_reset_sequencer #(
    .step_cycles_p (4),
    .token_cycles_p(4)
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
    , .count_width_p(2)
`endif
  ) dut1 (
    .clk_i              (clk),
    .reset_i            (reset1),
    .start_i            (start1),
    .uplink_reset_o     (up1),
    .async_token_reset_o(tok1),
    .downlink_reset_o   (dn1),
    .downstream_reset_o (ds1),
    .busy_o             (busy1),
    .done_o             (done1)
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
    , .seq_count_o      (cnt1)
`endif
  );

  bsg_link_sdr_reset_sequencer #(
    .step_cycles_p (1),
    .token_cycles_p(3)
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
    , .count_width_p(8)
`endif
  ) dut2 (
    .clk_i              (clk),
    .reset_i            (reset2),
    .start_i            (start2),
    .uplink_reset_o     (up2),
    .async_token_reset_o(tok2),
    .downlink_reset_o   (dn2),
    .downstream_reset_o (ds2),
    .busy_o             (busy2),
    .done_o             (done2)
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
    , .seq_count_o      (cnt2)
`endif
  );

  wire [5:0] out1 = {up1, tok1, dn1, ds1, busy1, done1};
  wire [5:0] out2 = {up2, tok2, dn2, ds2, busy2, done2};

  // Expected {up,tok,dn,ds,busy,done} after edge e, given the hand-computed edge of each change.
  function automatic logic [5:0] exp_outs(input int e, input int t_on, input int t_off,
                                          input int up_rel, input int dn_rel,
                                          input int core_rel, input int done_at);
    return {e < up_rel, (e >= t_on) && (e < t_off), e < dn_rel, e < core_rel,
            e < done_at, e >= done_at};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset1 = 1'b1; start1 = 1'b0;
    reset2 = 1'b1; start2 = 1'b0;
    repeat (3) tick();
    tests++;
    if (out1 !== RST_VEC) begin
      fails++;
      $display("FAIL reset_dut1 got=%b want=%b", out1, RST_VEC);
    end
    tests++;
    if (out2 !== RST_VEC) begin
      fails++;
      $display("FAIL reset_dut2 got=%b want=%b", out2, RST_VEC);
    end
  endtask

  task automatic test_step4();
    logic [5:0] want;
    reset1 = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      want = exp_outs(e, 4, 8, 12, 16, 20, 24);
      tests++;
      if (out1 !== want) begin
        fails++;
        $display("FAIL step4 edge=%0d got=%b want=%b", e, out1, want);
      end
    end
  endtask

  task automatic test_step1_token3();
    logic [5:0] want;
    reset2 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      want = exp_outs(e, 1, 4, 5, 6, 7, 8);
      tests++;
      if (out2 !== want) begin
        fails++;
        $display("FAIL step1_tok3 edge=%0d got=%b want=%b", e, out2, want);
      end
    end
  endtask

  task automatic test_restart();
    logic [5:0] want;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tests++;
    if (out1 !== RST_VEC) begin
      fails++;
      $display("FAIL restart_entry got=%b want=%b", out1, RST_VEC);
    end
    for (int e = 1; e <= 26; e++) begin
      tick();
      want = exp_outs(e, 4, 8, 12, 16, 20, 24);
      tests++;
      if (out1 !== want) begin
        fails++;
        $display("FAIL restart edge=%0d got=%b want=%b", e, out1, want);
      end
    end
  endtask

  task automatic test_start_held();
    logic [5:0] want;
    reset1 = 1'b1;
    start1 = 1'b1;
    repeat (2) tick();
    reset1 = 1'b0;
    for (int e = 1; e <= 49; e++) begin
      tick();
      if (e < 25) want = exp_outs(e, 4, 8, 12, 16, 20, 24);
      else        want = exp_outs(e - 25, 4, 8, 12, 16, 20, 24);
      tests++;
      if (out1 !== want) begin
        fails++;
        $display("FAIL start_held edge=%0d got=%b want=%b", e, out1, want);
      end
    end
    start1 = 1'b0;
  endtask

  task automatic test_midseq_reset();
    logic [5:0] want;
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      tick();
      want = exp_outs(e, 4, 8, 12, 16, 20, 24);
      tests++;
      if (out1 !== want) begin
        fails++;
        $display("FAIL midseq_pre edge=%0d got=%b want=%b", e, out1, want);
      end
    end
    reset1 = 1'b1;
    tick();
    tests++;
    if (out1 !== RST_VEC) begin
      fails++;
      $display("FAIL midseq_reset edge=19 got=%b want=%b", out1, RST_VEC);
    end
    tick();
    reset1 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      want = exp_outs(e, 4, 8, 12, 16, 20, 24);
      tests++;
      if (out1 !== want) begin
        fails++;
        $display("FAIL midseq_fresh edge=%0d got=%b want=%b", e, out1, want);
      end
    end
  endtask

`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
  task automatic test_seq_count();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset1 = 1'b1;
    tick();
    tests++;
    if (cnt1 !== 2'd0) begin
      fails++;
      $display("FAIL count_reset got=%0d want=0", cnt1);
    end
    reset1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
      end
      repeat (24) tick();
      tests++;
      if (cnt1 !== want[k]) begin
        fails++;
        $display("FAIL count_seq%0d got=%0d want=%0d", k + 1, cnt1, want[k]);
      end
    end
    reset1 = 1'b1;
    tick();
    tests++;
    if (cnt1 !== 2'd0) begin
      fails++;
      $display("FAIL count_clear got=%0d want=0", cnt1);
    end
    reset1 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_step4();
    test_step1_token3();
    test_restart();
    test_start_held();
    test_midseq_reset();
`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
    test_seq_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
